multicycle_stage_seq: RTL and testbench

Parametrised multicycle stage sequencer that generalises the fixed five-stage counter of the MUSA core's ID-stage control. It sits beside the opcode decoder and consumes per-instruction class flags. It produces the stage number and the one-cycle write/stack/memory strobes that gate the PC, register file, stack and data memory. Over the fixed counter it adds variable instruction length, a data-memory ready handshake with a timeout abort, a global hold, and a halted state with resume.

---
 rtl/musa_ctrl_pkg.sv | 18 +
 rtl/mem_wait_timer.sv | 30 +++
 rtl/multicycle_stage_seq.sv | 104 ++++++++++
 tb/tb_multicycle_stage_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/musa_ctrl_pkg.sv
// Shared control definitions for the MUSA multicycle sequencer.
// State encodings, default MEM timeout and the HALTED code.
package musa_ctrl_pkg;

   localparam int MEM_TIMEOUT_DEF = 15;

   localparam logic [2:0] HALTED_ENC = 3'd7;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALTED = HALTED_ENC
   } stage_e;

endpackage

// File: rtl/mem_wait_timer.sv
// MEM wait counter: clear, count while enabled, flag the last
// allowed wait cycle through expire.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   // Wait-cycle counter, cleared whenever the sequencer is outside MEM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else if (clr)
         cnt_q <= '0;
      else if (en && !expire)
         cnt_q <= cnt_q + 1'b1;
   end

   assign expire = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_stage_seq.sv
// Multicycle stage sequencer with MEM handshake, timeout, hold, halt.
// Define STAGE_SEQ_MEM_SKIP_EN to let non-memory ops bypass MEM.
module multicycle_stage_seq
   import musa_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int STAGE_W     = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hold,
   input  logic               is_mem,
   input  logic               writes_reg,
   input  logic               is_stack,
   input  logic               is_halt,
   input  logic               mem_ready,
   input  logic               resume,
   output logic [STAGE_W-1:0] stage,
   output logic               pc_write,
   output logic               reg_write_en,
   output logic               push_pop_en,
   output logic               mem_strobe,
   output logic               halted,
   output logic               mem_timeout
);

   stage_e state_q, state_d;
   logic   tmo_q, tmo_d;
   logic   expire;
   logic   in_mem;
   logic   t_clr, t_en;

   assign in_mem = (state_q == ST_MEM);
   assign t_clr  = !in_mem;
   assign t_en   = in_mem && is_mem && !mem_ready && !hold;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (t_clr),
      .en    (t_en),
      .expire(expire)
   );

   // State and timeout-pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state logic; hold freezes everything and suppresses aborts.
   always_comb begin
      state_d = state_q;
      tmo_d   = 1'b0;
      unique case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXEC;
`ifdef STAGE_SEQ_MEM_SKIP_EN
         ST_EXEC:   state_d = is_mem ? ST_MEM : ST_WB;
`else
         ST_EXEC:   state_d = ST_MEM;
`endif
         ST_MEM: begin
            if (!is_mem || mem_ready) begin
               state_d = ST_WB;
            end else if (expire) begin
               state_d = ST_FETCH;
               tmo_d   = 1'b1;
            end
         end
         ST_WB:     state_d = is_halt ? ST_HALTED : ST_FETCH;
         ST_HALTED: state_d = resume ? ST_FETCH : ST_HALTED;
         default:   state_d = ST_FETCH;
      endcase
      if (hold) begin
         state_d = state_q;
         tmo_d   = 1'b0;
      end
   end

   // Strobes decoded from the registered state, gated by hold.
   always_comb begin
      push_pop_en  = (state_q == ST_EXEC) && is_stack && !hold;
`ifdef STAGE_SEQ_MEM_SKIP_EN
      mem_strobe   = in_mem && !hold;
`else
      mem_strobe   = in_mem && is_mem && !hold;
`endif
      pc_write     = (state_q == ST_WB) && !is_halt && !hold;
      reg_write_en = (state_q == ST_WB) && writes_reg && !hold;
      halted       = (state_q == ST_HALTED);
   end

   assign stage       = STAGE_W'(state_q);
   assign mem_timeout = tmo_q;

endmodule

// File: tb/tb_multicycle_stage_seq.sv
// Directed bench for multicycle_stage_seq.
// Expectations adapt to STAGE_SEQ_MEM_SKIP_EN.
module tb_multicycle_stage_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       hold, is_mem, writes_reg, is_stack, is_halt;
   logic       mem_ready, resume;
   logic [2:0] stage;
   logic       pc_write, reg_write_en, push_pop_en;
   logic       mem_strobe, halted, mem_timeout;

   int n_cmp = 0;
   int n_err = 0;

   multicycle_stage_seq #(
      .MEM_TIMEOUT(15),
      .STAGE_W    (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .hold        (hold),
      .is_mem      (is_mem),
      .writes_reg  (writes_reg),
      .is_stack    (is_stack),
      .is_halt     (is_halt),
      .mem_ready   (mem_ready),
      .resume      (resume),
      .stage       (stage),
      .pc_write    (pc_write),
      .reg_write_en(reg_write_en),
      .push_pop_en (push_pop_en),
      .mem_strobe  (mem_strobe),
      .halted      (halted),
      .mem_timeout (mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, ".stage"}, 32'(stage), 0);
      chk({tag, ".pc"}, 32'(pc_write), 0);
      chk({tag, ".rw"}, 32'(reg_write_en), 0);
      chk({tag, ".pp"}, 32'(push_pop_en), 0);
      chk({tag, ".ms"}, 32'(mem_strobe), 0);
      chk({tag, ".hl"}, 32'(halted), 0);
      chk({tag, ".to"}, 32'(mem_timeout), 0);
   endtask

   initial begin
      reset = 1'b0; hold = 1'b0; is_mem = 1'b0; writes_reg = 1'b0;
      is_stack = 1'b0; is_halt = 1'b0; mem_ready = 1'b0;
      resume = 1'b0;
      #1;
      all_zero("rst");
      tick();
      tick();
      reset = 1'b1;
      chk("fetch0", 32'(stage), 0);

      // ADDI
      writes_reg = 1'b1;
      tick(); chk("addi.dec", 32'(stage), 1);
      tick(); chk("addi.ex", 32'(stage), 2);
      chk("addi.ex.pc", 32'(pc_write), 0);
`ifndef STAGE_SEQ_MEM_SKIP_EN
      tick(); chk("addi.mem", 32'(stage), 3);
      chk("addi.mem.ms", 32'(mem_strobe), 0);
`endif
      tick(); chk("addi.wb", 32'(stage), 4);
      chk("addi.wb.pc", 32'(pc_write), 1);
      chk("addi.wb.rw", 32'(reg_write_en), 1);
      tick(); chk("addi.f", 32'(stage), 0);
      chk("addi.f.pc", 32'(pc_write), 0);
      chk("addi.f.rw", 32'(reg_write_en), 0);

      // LW, ready on 4th MEM cycle
      is_mem = 1'b1;
      tick(); tick(); tick();
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         chk("lw.mem", 32'(stage), 3);
         chk("lw.ms", 32'(mem_strobe), 1);
         chk("lw.rw0", 32'(reg_write_en), 0);
         tick();
      end
      mem_ready = 1'b0;
      chk("lw.wb", 32'(stage), 4);
      chk("lw.ms.off", 32'(mem_strobe), 0);
      chk("lw.rw", 32'(reg_write_en), 1);
      tick(); chk("lw.f", 32'(stage), 0);
      chk("lw.rw.off", 32'(reg_write_en), 0);

      // SW timeout
      writes_reg = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 15; i++) begin
         chk("sw.mem", 32'(stage), 3);
         chk("sw.to0", 32'(mem_timeout), 0);
         chk("sw.pc0", 32'(pc_write), 0);
         tick();
      end
      chk("sw.abort", 32'(stage), 0);
      chk("sw.to", 32'(mem_timeout), 1);
      chk("sw.abort.pc", 32'(pc_write), 0);
      tick(); chk("sw.retry", 32'(stage), 1);
      chk("sw.to.off", 32'(mem_timeout), 0);
      // retry with ready on 15th MEM cycle
      tick(); tick();
      for (int i = 0; i < 15; i++) begin
         mem_ready = (i == 14);
         chk("sw2.mem", 32'(stage), 3);
         tick();
      end
      mem_ready = 1'b0;
      chk("sw2.wb", 32'(stage), 4);
      chk("sw2.to", 32'(mem_timeout), 0);
      chk("sw2.pc", 32'(pc_write), 1);
      tick(); chk("sw2.f", 32'(stage), 0);
      chk("sw2.f.to", 32'(mem_timeout), 0);

      // CALL with hold in EXEC
      is_mem = 1'b0; is_stack = 1'b1;
      chk("call.f.pp", 32'(push_pop_en), 0);
      tick(); chk("call.d.pp", 32'(push_pop_en), 0);
      tick(); chk("call.ex", 32'(stage), 2);
      chk("call.ex.pp", 32'(push_pop_en), 1);
      hold = 1'b1;
      #1; chk("call.h.pp", 32'(push_pop_en), 0);
      tick(); chk("call.h1", 32'(stage), 2);
      chk("call.h1.pp", 32'(push_pop_en), 0);
      tick(); chk("call.h2", 32'(stage), 2);
      hold = 1'b0;
      #1; chk("call.rel.pp", 32'(push_pop_en), 1);
      tick(); chk("call.post.pp", 32'(push_pop_en), 0);
`ifndef STAGE_SEQ_MEM_SKIP_EN
      tick();
`endif
      chk("call.wb", 32'(stage), 4);
      tick(); chk("call.f", 32'(stage), 0);
      is_stack = 1'b0;

      // HALT, resume ignored until halted
      is_halt = 1'b1; resume = 1'b1;
      tick(); chk("halt.d", 32'(stage), 1);
      tick(); chk("halt.ex", 32'(stage), 2);
`ifndef STAGE_SEQ_MEM_SKIP_EN
      tick(); chk("halt.mem", 32'(stage), 3);
`endif
      tick(); chk("halt.wb", 32'(stage), 4);
      chk("halt.wb.pc", 32'(pc_write), 0);
      resume = 1'b0;
      tick(); chk("halt.st", 32'(stage), 7);
      chk("halt.hl", 32'(halted), 1);
      chk("halt.pc", 32'(pc_write), 0);
      tick(); chk("halt.stay", 32'(stage), 7);
      resume = 1'b1;
      tick(); chk("halt.res", 32'(stage), 0);
      chk("halt.hl0", 32'(halted), 0);
      resume = 1'b0; is_halt = 1'b0;

      // reset mid MEM wait
      is_mem = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      chk("rm.mem", 32'(stage), 3);
      chk("rm.ms", 32'(mem_strobe), 1);
      reset = 1'b0;
      #1; all_zero("rm");
      tick();
      reset = 1'b1;
      chk("rm.f", 32'(stage), 0);
      tick(); tick(); tick();
      for (int i = 0; i < 15; i++) begin
         chk("rm.wait", 32'(stage), 3);
         tick();
      end
      chk("rm.abort", 32'(stage), 0);
      chk("rm.to", 32'(mem_timeout), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
